// File: rtl/stream_engine_router.sv
// Routes one DMA read stream to a selected compute engine and merges that engine's output
// back onto the DMA write stream, counting beats both ways and framing the job with m_last/done.
module stream_engine_router #(
    parameter int DATA_W = 128,
    parameter int N_ENG  = 4,
    parameter int SEL_W  = 2,
    parameter int LEN_W  = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SEL_W-1:0]        eng_sel,
    input  logic [LEN_W-1:0]        rd_len,
    input  logic [LEN_W-1:0]        wr_len,
    output logic                    busy,
    output logic                    done,
    output logic                    sel_err,
    output logic                    dma_rd_start,
    output logic                    dma_wr_start,
    input  logic [DATA_W-1:0]       s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [N_ENG*DATA_W-1:0] eng_s_data,
    output logic [N_ENG-1:0]        eng_s_valid,
    input  logic [N_ENG-1:0]        eng_s_ready,
    input  logic [N_ENG*DATA_W-1:0] eng_m_data,
    input  logic [N_ENG-1:0]        eng_m_valid,
    output logic [N_ENG-1:0]        eng_m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    localparam logic [SEL_W:0] NUM_ENG = (SEL_W+1)'(N_ENG);

    state_t           state, state_next;
    logic [SEL_W-1:0] sel_q;
    logic [LEN_W-1:0] rd_len_q, wr_len_q, rd_cnt, wr_cnt;
    logic             sel_ok, accept, rd_fin, wr_fin, in_act, out_act;

    assign sel_ok  = ({1'b0, eng_sel} < NUM_ENG);
    assign accept  = (state == IDLE) && start && sel_ok;
    assign rd_fin  = (rd_cnt == rd_len_q);
    assign wr_fin  = (wr_cnt == wr_len_q);
    assign in_act  = (state == RUN) && !rd_fin;
    assign out_act = (state == RUN) && !wr_fin;

    assign busy         = (state == ARM) || (state == RUN);
    assign done         = (state == DONE);
    assign dma_rd_start = (state == ARM);
    assign dma_wr_start = (state == ARM);
    assign eng_s_data   = {N_ENG{s_data}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ARM;
            ARM:     state_next = RUN;
            RUN:     if (rd_fin && wr_fin) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counters only advance on real handshakes, which are already gated off once a side finishes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q    <= '0;
            rd_len_q <= '0;
            wr_len_q <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            sel_err  <= 1'b0;
        end else begin
            sel_err <= (state == IDLE) && start && !sel_ok;
            if (accept) begin
                sel_q    <= eng_sel;
                rd_len_q <= rd_len;
                wr_len_q <= wr_len;
                rd_cnt   <= '0;
                wr_cnt   <= '0;
            end else begin
                if (s_valid && s_ready) rd_cnt <= rd_cnt + LEN_W'(1);
                if (m_valid && m_ready) wr_cnt <= wr_cnt + LEN_W'(1);
            end
        end
    end

    always_comb begin
        eng_s_valid = '0;
        eng_m_ready = '0;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        for (int k = 0; k < N_ENG; k++) begin
            if (sel_q == SEL_W'(k)) begin
                if (in_act) begin
                    eng_s_valid[k] = s_valid;
                    s_ready        = eng_s_ready[k];
                end
                if (out_act) begin
                    m_valid        = eng_m_valid[k];
                    m_data         = eng_m_data[k*DATA_W +: DATA_W];
                    eng_m_ready[k] = m_ready;
                end
            end
        end
        m_last = m_valid && (wr_cnt == wr_len_q - LEN_W'(1));
    end

endmodule
